// File: rtl/dmem_block_mover.sv
// dmem_block_mover: bus initiator for the 256x16 data memory port.
// Performs a block copy (memory to memory) or a block fill (constant to
// memory) of up to 256 words, started by a one-cycle request.
// Optional build macro DMEM_BLOCK_MOVER_CHECKSUM_EN adds a 'checksum' output
// holding the modulo-2^DW sum of every word written by the current operation.

module dmem_block_mover #(
    parameter int AW = 8,
    parameter int DW = 16,
    parameter int LW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [LW-1:0] len,
    input  logic [DW-1:0] fill_value,
    output logic          busy,
    output logic          done,
    output logic          ram_ena,
    output logic          wena,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] wdata,
    input  logic [DW-1:0] rdata
`ifdef DMEM_BLOCK_MOVER_CHECKSUM_EN
    ,
    output logic [DW-1:0] checksum
`endif
);

    // Largest transfer is one full pass over the address space.
    localparam logic [LW-1:0] MAX_LEN = LW'(2 ** AW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [LW-1:0] len_q, len_d;
    logic          mode_q, mode_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [LW-1:0] len_clamped;
    logic [LW-1:0] idx_inc;

    // Outputs decode from registers only, so start never reaches a pin combinationally.
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign ram_ena = (state_q == RD) || (state_q == WR);
    assign wena    = (state_q == WR);
    assign addr    = addr_q;
    assign wdata   = wdata_q;

    assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
    assign idx_inc     = idx_q + LW'(1);

    // Next-state logic; addr and wdata are computed one step ahead so they are registered.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        mode_d  = mode_q;
        src_d   = src_q;
        dst_d   = dst_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d = mode;
                    src_d  = src_addr;
                    dst_d  = dst_addr;
                    len_d  = len_clamped;
                    idx_d  = '0;
                    if (len_clamped == '0) begin
                        state_d = DONE;
                    end else if (mode) begin
                        state_d = WR;
                        addr_d  = dst_addr;
                        wdata_d = fill_value;
                    end else begin
                        state_d = RD;
                        addr_d  = src_addr;
                    end
                end
            end
            RD: begin
                state_d = WR;
                addr_d  = dst_q + idx_q[AW-1:0];
                wdata_d = rdata;
            end
            WR: begin
                idx_d = idx_inc;
                if (idx_inc == len_q) begin
                    state_d = DONE;
                end else if (mode_q) begin
                    state_d = WR;
                    addr_d  = dst_q + idx_inc[AW-1:0];
                end else begin
                    state_d = RD;
                    addr_d  = src_q + idx_inc[AW-1:0];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and operand registers; reset aborts any transfer immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            mode_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef DMEM_BLOCK_MOVER_CHECKSUM_EN
    // Running sum of committed words; cleared on an accepted start, held afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (state_q == IDLE && start) begin
            checksum <= '0;
        end else if (state_q == WR) begin
            checksum <= checksum + wdata_q;
        end
    end
`endif

endmodule
